fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of one `self_fifo` instance between `NUM_REQ` producer engines (e.g. PE result streams) in the accelerator datapath. Each producer offers beats on a valid/ready handshake. The arbiter grants one producer at a time, holds the grant for up to `BURST_LEN` beats, and forwards the beats through a one-entry output register that drives the FIFO's `wr_en` and `data_in`. The arbiter honours the FIFO's `full` flag, so no beat is ever lost or duplicated.

## Interface
Parameters:
- `DATA_WIDTH`, 32: beat width; must match the FIFO's `DATA_WIDTH`.
- `NUM_REQ`, 4: number of producers; must be at least 2.
- `BURST_LEN`, 4: maximum beats per grant; must be at least 1. Used only when `FIFO_ARB_BURST_EN` is defined.

Ports (`IW` = `$clog2(NUM_REQ)`):
- `sys_clk`, input, 1: single clock; all state is updated on its rising edge.
- `sys_rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, `NUM_REQ`: bit i means producer i is offering a beat.
- `req_data`, input, `NUM_REQ*DATA_WIDTH`: producer i's beat, in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`, output, `NUM_REQ`: combinational. Bit i high means producer i's beat is accepted at this edge if `req_valid[i]` is also high.
- `fifo_full`, input, 1: `full` from the FIFO.
- `fifo_wr_en`, output, 1: FIFO write strobe; equals `out_valid & ~fifo_full`.
- `fifo_wr_data`, output, `DATA_WIDTH`: registered beat driven to the FIFO.
- `grant_valid`, output, 1: registered; high while in state GRANT.
- `grant_id`, output, `IW`: registered; index of the currently granted producer.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - `rr_ptr` [IW-1:0]: round-robin priority pointer.
  - `beat_cnt`: counts beats in the current grant; wide enough to hold `BURST_LEN`.
  - `out_valid`: marks the output register as holding a beat.
- Reset values: state IDLE, `rr_ptr` 0, `beat_cnt` 0, `out_valid` 0, `fifo_wr_data` 0, `grant_valid` 0, `grant_id` 0. With these, `req_ready` and `fifo_wr_en` are both 0.
- IDLE:
  - If any `req_valid` bit is high, select the first set index searching upward from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - Load that index into `grant_id`, clear `beat_cnt`, and go to GRANT.
  - If no `req_valid` bit is high, stay in IDLE.
- GRANT: `req_ready[grant_id] = ~out_valid | ~fifo_full`; all other `req_ready` bits are 0.
- Accept (at an edge where `req_valid[g]` and `req_ready[g]` are both high, `g = grant_id`):
  - `fifo_wr_data` ← `req_data[g]`.
  - `out_valid` ← 1.
  - `beat_cnt` increments by 1.
- Drain: at an edge where `fifo_wr_en` is high and no beat is accepted, `out_valid` ← 0. A simultaneous drain and accept keeps `out_valid` at 1 and loads the new data.
- Release GRANT → IDLE with `rr_ptr` ← (`grant_id` + 1) mod `NUM_REQ` when either:
  - an accept makes `beat_cnt` reach the burst limit, or
  - `req_valid[grant_id]` is low at an edge where no beat is accepted.
- `fifo_full` high never causes a release; the grant holds while stalled.
- `req_valid` may drop without handshake; the next beat from that producer requires a new grant.

## Timing
- Arbitration: 1 cycle. A request seen in IDLE at edge k gives `grant_valid` and `req_ready` high in cycle k+1.
- Datapath latency: a beat accepted at edge k has `fifo_wr_en` high in cycle k+1 if `fifo_full` is low.
- Throughput:
  - Within a grant, 1 beat/cycle while the FIFO is not full.
  - Each grant switch costs 1 idle cycle.
- Full: with `out_valid` = 1 and `fifo_full` = 1:
  - `req_ready` = 0 and `fifo_wr_en` = 0.
  - `fifo_wr_data` is held stable until `fifo_full` falls.
- Wrap-around: `rr_ptr` wraps from `NUM_REQ-1` to 0. Requesters that were not granted are serviced within `NUM_REQ-1` grants.
- Reset mid-operation: all registers return to their reset values asynchronously. The beat in the output register is discarded, so upstream producers must be reset together with the arbiter.

## Configuration
- `FIFO_ARB_BURST_EN` defined: the burst limit is `BURST_LEN`.
- Not defined:
  - The burst limit is 1: every grant carries exactly one beat, giving strict per-beat round-robin.
  - `BURST_LEN` is ignored.

## Test plan
- Reset: assert `sys_rst` for 3 cycles with all `req_valid` = 4'b1111 → `req_ready` = 0, `fifo_wr_en` = 0, `grant_valid` = 0, `grant_id` = 0 throughout. First `grant_id` = 0 one cycle after release.
- Single stream: producer 2 sends 0xA0–0xA7 continuously with `FIFO_ARB_BURST_EN` defined and `BURST_LEN` = 4 → FIFO receives A0..A7 in order, with one gap cycle after A3.
- Fairness: `req_valid` = 4'b1111 held for 40 cycles → `grant_id` sequence 0,1,2,3,0,… with 4 beats each (with macro) or 1 beat each (without macro).
- Backpressure: raise `fifo_full` for 5 cycles mid-burst → `fifo_wr_data` is held, `fifo_wr_en` = 0, no producer beat is lost or duplicated, `grant_id` is unchanged.
- Early release: producer 1 drops `req_valid` after 2 of 4 beats while producer 3 is waiting → producer 3 is granted two cycles later and `rr_ptr` becomes 2.
- Mid-burst reset: assert `sys_rst` while a beat is in the output register → `fifo_wr_en` = 0 immediately, and the FSM is in IDLE with `rr_ptr` = 0 after release.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NUM_REQ producers. A granted producer streams beats through a one-entry
// output register that drives the FIFO write strobe and data.
// Optional feature macro: FIFO_ARB_BURST_EN. When defined, a grant may carry
// up to BURST_LEN beats. When undefined, every grant carries exactly one beat.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  // Counter is sized for BURST_LEN in both builds so one layout serves both.
  localparam int unsigned CW = $clog2(BURST_LEN + 1);
`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BurstLimit = BURST_LEN;
`else
  localparam int unsigned BurstLimit = 1;
`endif

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                r_state, w_state_next;
  logic [IW-1:0]         r_rr_ptr, w_rr_ptr_next;
  logic [CW-1:0]         r_beat_cnt, w_beat_cnt_next;
  logic                  r_out_valid, w_out_valid_next;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_next;
  logic                  r_grant_valid;
  logic [IW-1:0]         r_grant_id, w_grant_id_next;

  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
  logic                  w_pick_found;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_in_grant;
  logic                  w_slot_free;
  logic                  w_gnt_valid;
  logic                  w_accept;
  logic [CW-1:0]         w_beat_inc;
  logic                  w_last_beat;
  logic [IW-1:0]         w_rr_after;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_in_grant  = (r_state == StGrant);
  // Output register can take a beat if empty or draining this cycle.
  assign w_slot_free = ~r_out_valid | ~fifo_full;
  assign w_gnt_valid = req_valid[r_grant_id];
  assign w_accept    = w_in_grant & w_gnt_valid & w_slot_free;
  assign w_beat_inc  = r_beat_cnt + CW'(1);
  assign w_last_beat = (w_beat_inc == CW'(BurstLimit));
  assign w_rr_after  = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + IW'(1);

  assign fifo_wr_en   = r_out_valid & ~fifo_full;
  assign fifo_wr_data = r_wr_data;
  assign grant_valid  = r_grant_valid;
  assign grant_id     = r_grant_id;

  // Pick the first requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : p_pick
    int unsigned idx;
    logic [IW-1:0] cand;
    idx          = 0;
    cand         = '0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(r_rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!w_pick_found && req_valid[cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = cand;
      end
    end
  end

  // Only the granted producer may be ready, and only when the slot is free.
  always_comb begin
    req_ready = '0;
    if (w_in_grant) req_ready[r_grant_id] = w_slot_free;
  end

  // FSM next state, grant bookkeeping and round-robin pointer update.
  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_beat_cnt_next = r_beat_cnt;
    w_grant_id_next = r_grant_id;
    unique case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_grant_id_next = w_pick_idx;
          w_beat_cnt_next = '0;
          w_state_next    = StGrant;
        end
      end
      StGrant: begin
        if (w_accept) w_beat_cnt_next = w_beat_inc;
        // A full FIFO only stalls; release needs burst end or a dropped valid.
        if ((w_accept && w_last_beat) || !w_gnt_valid) begin
          w_state_next  = StIdle;
          w_rr_ptr_next = w_rr_after;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output register: accept loads a beat, a drain without accept empties it.
  always_comb begin
    w_out_valid_next = r_out_valid;
    w_wr_data_next   = r_wr_data;
    if (w_accept) begin
      w_out_valid_next = 1'b1;
      w_wr_data_next   = w_req_data[r_grant_id];
    end else if (fifo_wr_en) begin
      w_out_valid_next = 1'b0;
    end
  end

  // State registers with asynchronous reset; a held beat is discarded.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_beat_cnt    <= '0;
      r_out_valid   <= 1'b0;
      r_wr_data     <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_rr_ptr      <= w_rr_ptr_next;
      r_beat_cnt    <= w_beat_cnt_next;
      r_out_valid   <= w_out_valid_next;
      r_wr_data     <= w_wr_data_next;
      r_grant_valid <= (w_state_next == StGrant);
      r_grant_id    <= w_grant_id_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter. Expectations follow
// the build: FIFO_ARB_BURST_EN defined gives 4 beats per grant, else 1.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 32;
  localparam int NR = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif

  logic                 sys_clk = 1'b0;
  logic                 sys_rst;
  logic [NR-1:0]        req_valid;
  logic [NR*DW-1:0]     req_data;
  logic [NR-1:0]        req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_wr_data;
  logic                 grant_valid;
  logic [1:0]           grant_id;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .BURST_LEN  (4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int unsigned p_seq [NR];
  logic [31:0] wr_q [$];
  int          wr_cyc_q [$];
  int          g_id_q [$];
  int          g_beats_q [$];
  logic        prev_gv;
  logic [NR-1:0] acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int id, input int unsigned s);
    return 32'(id << 16) | (s & 32'h0000_FFFF);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = beat(i, p_seq[i]);
  endtask

  // Record handshakes, FIFO writes and grants, then advance one cycle.
  task automatic adv();
    acc = req_valid & req_ready;
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (grant_valid && !prev_gv) begin
      g_id_q.push_back(int'(grant_id));
      g_beats_q.push_back(0);
    end
    if (acc != '0 && g_beats_q.size() > 0) g_beats_q[g_beats_q.size()-1]++;
    prev_gv = grant_valid;
    @(negedge sys_clk);
    for (int i = 0; i < NR; i++) if (acc[i]) p_seq[i]++;
    drive_data();
    cyc++;
  endtask

  task automatic tick();
    #1;
    adv();
  endtask

  task automatic do_reset();
    sys_rst   = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) p_seq[i] = 0;
    drive_data();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    wr_q.delete();
    wr_cyc_q.delete();
    g_id_q.delete();
    g_beats_q.delete();
    prev_gv = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every producer requesting.
    sys_rst   = 1'b1;
    fifo_full = 1'b0;
    req_valid = 4'b1111;
    prev_gv   = 1'b0;
    for (int i = 0; i < NR; i++) p_seq[i] = 0;
    drive_data();
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      #1;
      check_eq("rst_ready", 32'(req_ready), 0);
      check_eq("rst_wren", 32'(fifo_wr_en), 0);
      check_eq("rst_gvalid", 32'(grant_valid), 0);
      check_eq("rst_gid", 32'(grant_id), 0);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tick();
    #1;
    check_eq("rst_first_gvalid", 32'(grant_valid), 1);
    check_eq("rst_first_gid", 32'(grant_id), 0);

    // Single stream from producer 2: A0..A7, a gap after each full burst.
    do_reset();
    p_seq[2] = 32'hA0;
    drive_data();
    req_valid = 4'b0100;
    for (int t = 0; t < 60 && p_seq[2] < 32'hA8; t++) tick();
    check_eq("s2_beats", p_seq[2], 32'hA8);
    req_valid = '0;
    repeat (4) tick();
    check_eq("s2_nwrites", 32'(wr_q.size()), 8);
    for (int k = 0; k < 8 && k < wr_q.size(); k++) begin
      check_eq("s2_data", wr_q[k], beat(2, 32'hA0 + k));
      if (k > 0) check_eq("s2_gap", 32'(wr_cyc_q[k] - wr_cyc_q[k-1]), ((k % BL) == 0) ? 2 : 1);
    end

    // Fairness: all four requesting for 40 cycles.
    do_reset();
    req_valid = 4'b1111;
    repeat (40) tick();
    req_valid = '0;
    repeat (4) tick();
    check_eq("fair_ngrants", 32'(g_id_q.size() >= 8), 1);
    for (int k = 0; k < 8 && k < g_id_q.size(); k++) begin
      check_eq("fair_gid", 32'(g_id_q[k]), k % 4);
      if (k < 6) check_eq("fair_beats", 32'(g_beats_q[k]), BL);
    end
    check_eq("fair_nwrites", 32'(wr_q.size() >= 16), 1);
    for (int k = 0; k < 16 && k < wr_q.size(); k++) begin
      check_eq("fair_data", wr_q[k], beat((k / BL) % 4, ((k / BL) / 4) * BL + (k % BL)));
    end

    // Backpressure: FIFO full for 5 cycles while producer 1 streams.
    do_reset();
    req_valid = 4'b0010;
    repeat (6) tick();
    fifo_full = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_eq("bp_wren", 32'(fifo_wr_en), 0);
      if (j > 0) begin
        check_eq("bp_ready", 32'(req_ready), 0);
        check_eq("bp_hold", fifo_wr_data, beat(1, p_seq[1] - 1));
        check_eq("bp_gid", 32'(grant_id), 1);
      end
      adv();
    end
    fifo_full = 1'b0;
    for (int t = 0; t < 80 && p_seq[1] < 12; t++) tick();
    req_valid = '0;
    repeat (4) tick();
    check_eq("bp_nwrites", 32'(wr_q.size()), p_seq[1]);
    for (int k = 0; k < wr_q.size(); k++) check_eq("bp_data", wr_q[k], beat(1, k));

    // Early release: producer 1 drops valid while 0 and 3 are waiting.
    do_reset();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1011;
`ifdef FIFO_ARB_BURST_EN
    tick();
    tick();
    req_valid = 4'b1001;
    #1;
    check_eq("er_hold_gv", 32'(grant_valid), 1);
    check_eq("er_hold_gid", 32'(grant_id), 1);
    adv();
    #1;
    check_eq("er_idle_gv", 32'(grant_valid), 0);
    adv();
    #1;
    check_eq("er_next_gv", 32'(grant_valid), 1);
    check_eq("er_next_gid", 32'(grant_id), 3);
    check_eq("er_p1_beats", p_seq[1], 2);
    adv();
`else
    tick();
    #1;
    check_eq("er_idle_gv", 32'(grant_valid), 0);
    adv();
    #1;
    check_eq("er_next_gv", 32'(grant_valid), 1);
    check_eq("er_next_gid", 32'(grant_id), 3);
    check_eq("er_p1_beats", p_seq[1], 1);
    adv();
`endif

    // Mid-burst reset with a beat in the output register.
    do_reset();
    req_valid = 4'b0010;
    tick();
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b0100;
    tick();
    tick();
    #1;
    check_eq("mr_pre_wren", 32'(fifo_wr_en), 1);
    sys_rst = 1'b1;
    #1;
    check_eq("mr_wren", 32'(fifo_wr_en), 0);
    check_eq("mr_gvalid", 32'(grant_valid), 0);
    check_eq("mr_gid", 32'(grant_id), 0);
    check_eq("mr_data", fifo_wr_data, 0);
    check_eq("mr_ready", 32'(req_ready), 0);
    req_valid = 4'b1001;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    prev_gv = 1'b0;
    tick();
    #1;
    check_eq("mr_after_gv", 32'(grant_valid), 1);
    check_eq("mr_after_gid", 32'(grant_id), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
